note_controller: RTL and testbench
==================================

# note_controller

Sequencing controller between the keypad encoder and the oscillator/waveform datapath. It consumes the encoder's priority keycode and its mode/sound button edges, and runs one of three play modes: live, hold (latch) or arpeggio. It drives the note number, gate and waveform selection that configure the tone generator.

## Interface
- STEP_CYCLES, default 500000: clock cycles per arpeggio step; legal range ≥ 2.
- DEPTH, default 8: arpeggio note buffer entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset; asynchronous, active-low
- keycode  input  4  encoder key, 0–12 = C(low)..C(high); 4'hF = no key. Values 13–14 are treated as 4'hF.
- mode_edge  input  1  one-cycle pulse; advance play mode
- sound_edge  input  1  one-cycle pulse; advance waveform
- note  output  4  note number to oscillator
- gate  output  1  oscillator enable
- wave_sel  output  2  0 square, 1 saw, 2 triangle, 3 sine
- mode  output  2  0 LIVE, 1 HOLD, 2 ARP; 3 never occurs

## Operation
- Reset values:
  - note = 0, gate = 0, wave_sel = 0, mode = 0 (LIVE).
  - prev_key = 4'hF; arp count = 0, idx = 0, step counter = 0.
- prev_key holds the registered keycode and updates every cycle.
- new_key is asserted when keycode ≠ 4'hF and keycode ≠ prev_key. Holding a key is therefore one event; sliding to another key is a new event.
- sound_edge: wave_sel increments mod 4 (3 → 0). This happens in every mode and is independent of all other events.
- mode_edge: mode advances 0 → 1 → 2 → 0. On the same edge:
  - gate ← 0; note is unchanged.
  - Arp buffer is cleared: count ← 0, idx ← 0.
  - Step counter ← 0.
  - Any new_key in that cycle is discarded, but prev_key still updates.
- LIVE:
  - If keycode ≠ 4'hF: note ← keycode, gate ← 1.
  - If keycode = 4'hF: gate ← 0 and note holds its last value.
- HOLD, on new_key:
  - If gate = 1 and keycode = note: gate ← 0 (toggle off).
  - Otherwise: note ← keycode, gate ← 1.
  - Key release has no effect.
- ARP buffer:
  - On new_key with count < DEPTH: buf[count] ← keycode, count ← count + 1.
  - On new_key with count = DEPTH: the key is ignored.
  - Duplicate notes are stored.
- ARP step counter:
  - Counts 0 .. STEP_CYCLES−1 continuously while mode = ARP and wraps to 0.
  - A tick is the cycle in which the counter equals STEP_CYCLES−1.
- ARP on a tick with count > 0:
  - note ← buf[idx], gate ← 1.
  - idx ← (idx + 1 = count) ? 0 : idx + 1.
- ARP with count = 0: gate = 0.
- Tick and new_key in the same cycle:
  - The append happens.
  - The tick uses the pre-append count for the idx wrap.
  - If the pre-append count = 0, no note plays on that tick.
- The step counter and buffer are idle and held at 0 outside ARP.

## Timing
- All outputs are registered. Response appears the cycle after the input event (1-cycle latency). There are no combinational paths from inputs to outputs.
- LIVE: keycode change → note/gate update at the next clk edge.
- ARP:
  - First note plays at the first tick after count becomes ≥ 1.
  - Subsequent notes follow every STEP_CYCLES cycles.
- Reset may be asserted at any time, including mid-arpeggio. All state returns to reset values immediately (asynchronously), and buffer contents become don't-care.
- mode_edge has priority over new_key and tick in the same cycle. sound_edge never conflicts with either.

## Test plan
- Reset/LIVE: release n_rst, drive keycode = 4, then 4'hF.
  - After reset: note = 0, gate = 0, mode = 0, wave_sel = 0.
  - One cycle after keycode = 4: note = 4, gate = 1.
  - One cycle after 4'hF: gate = 0, note = 4.
- Mode/wave cycling: pulse sound_edge 5 times and mode_edge 3 times.
  - wave_sel ends at 1.
  - mode steps 1, 2, 0, and gate = 0 after each mode_edge.
- HOLD toggle (mode = 1):
  - Press 7, release: gate = 1, note = 7.
  - Press 7 again: gate = 0.
  - Press 2: note = 2, gate = 1.
  - Hold 2 for 10 cycles: no further change.
- ARP playback (STEP_CYCLES = 4, DEPTH = 8, mode = 2): press 0, 4, 7 as separate presses.
  - Ticks produce note 0, 4, 7, 0, 4, … with gate = 1, spaced exactly 4 cycles apart.
- ARP full/clear: press 9 distinct-event keys (alternate 1 and 2).
  - count saturates at 8; the 9th key is ignored.
  - mode_edge → mode = 0, gate = 0, and the buffer is empty on re-entering ARP.
- Priority/reset:
  - mode_edge coincident with new_key: key not recorded.
  - Assert n_rst low mid-arpeggio: gate = 0, note = 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/note_controller.sv
// rtl/note_controller.sv - keypad-to-oscillator sequencer with live, hold and arpeggio play modes
module note_controller #(
  parameter int STEP_CYCLES = 500000,
  parameter int DEPTH       = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] keycode,
  input  logic       mode_edge,
  input  logic       sound_edge,
  output logic [3:0] note,
  output logic       gate,
  output logic [1:0] wave_sel,
  output logic [1:0] mode
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_LIVE = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_ARP  = 2'd2
  } mode_t;

  mode_t         state, state_nx;
  logic [3:0]    key, prev_key;
  logic [3:0]    note_nx;
  logic          gate_nx;
  logic [1:0]    wave_nx;
  logic [CW-1:0] count, count_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [SW-1:0] step, step_nx;
  logic [3:0]    note_buf [DEPTH];
  logic          buf_we;
  logic          new_key;
  logic          tick;

  // Codes 13..14 never come from a real key; fold them into "no key".
  assign key     = (keycode > 4'd12) ? 4'hF : keycode;
  assign new_key = (key != 4'hF) && (key != prev_key);
  assign tick    = (state == MODE_ARP) && (step == STEP_LAST);
  assign mode    = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= MODE_LIVE;
      prev_key <= 4'hF;
      note     <= 4'd0;
      gate     <= 1'b0;
      wave_sel <= 2'd0;
      count    <= '0;
      idx      <= '0;
      step     <= '0;
    end else begin
      state    <= state_nx;
      prev_key <= key;
      note     <= note_nx;
      gate     <= gate_nx;
      wave_sel <= wave_nx;
      count    <= count_nx;
      idx      <= idx_nx;
      step     <= step_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) note_buf[count[IW-1:0]] <= key;
  end

  always_comb begin
    state_nx = state;
    note_nx  = note;
    gate_nx  = gate;
    count_nx = count;
    idx_nx   = idx;
    step_nx  = step;
    buf_we   = 1'b0;
    wave_nx  = sound_edge ? wave_sel + 2'd1 : wave_sel;

    if (mode_edge) begin
      case (state)
        MODE_LIVE: state_nx = MODE_HOLD;
        MODE_HOLD: state_nx = MODE_ARP;
        default:   state_nx = MODE_LIVE;
      endcase
      gate_nx  = 1'b0;
      count_nx = '0;
      idx_nx   = '0;
      step_nx  = '0;
    end else begin
      case (state)
        MODE_LIVE: begin
          if (key != 4'hF) begin
            note_nx = key;
            gate_nx = 1'b1;
          end else begin
            gate_nx = 1'b0;
          end
        end
        MODE_HOLD: begin
          if (new_key) begin
            if (gate && (key == note)) begin
              gate_nx = 1'b0;
            end else begin
              note_nx = key;
              gate_nx = 1'b1;
            end
          end
        end
        MODE_ARP: begin
          step_nx = tick ? '0 : step + SW'(1);
          if (new_key && (count < DEPTH_C)) begin
            buf_we   = 1'b1;
            count_nx = count + CW'(1);
          end
          // Playback decisions use the count as it stood before any append this cycle.
          if (count == '0) begin
            gate_nx = 1'b0;
          end else if (tick) begin
            note_nx = note_buf[idx];
            gate_nx = 1'b1;
            idx_nx  = (({1'b0, idx} + CW'(1)) == count) ? '0 : idx + IW'(1);
          end
        end
        default: state_nx = MODE_LIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_controller.sv
// tb/tb_note_controller.sv - scoreboard bench for note_controller
module tb_note_controller;

  logic       clk;
  logic       n_rst;
  logic [3:0] keycode;
  logic       mode_edge;
  logic       sound_edge;
  logic [3:0] note;
  logic       gate;
  logic [1:0] wave_sel;
  logic [1:0] mode;

  note_controller #(.STEP_CYCLES(4), .DEPTH(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .keycode   (keycode),
    .mode_edge (mode_edge),
    .sound_edge(sound_edge),
    .note      (note),
    .gate      (gate),
    .wave_sel  (wave_sel),
    .mode      (mode)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] note;
    logic       gate;
    logic [1:0] wave;
    logic [1:0] mode;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each expectation is due at the negedge following the edge that consumes its stimulus.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (mon_e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: overdue at cycle %0d, was due at %0d", mon_e.name, cyc, mon_e.cyc);
      end else if (note !== mon_e.note || gate !== mon_e.gate ||
                   wave_sel !== mon_e.wave || mode !== mon_e.mode) begin
        n_bad++;
        $display("FAIL %s @%0d: got note=%0d gate=%0d wave=%0d mode=%0d, want note=%0d gate=%0d wave=%0d mode=%0d",
                 mon_e.name, cyc, note, gate, wave_sel, mode,
                 mon_e.note, mon_e.gate, mon_e.wave, mon_e.mode);
      end
    end
  end

  task automatic chk(input logic [3:0] kc, input logic me, input logic se, input string name,
                     input logic [3:0] n, input logic g, input logic [1:0] w, input logic [1:0] m);
    exp_t e;
    @(negedge clk);
    keycode    = kc;
    mode_edge  = me;
    sound_edge = se;
    e.cyc  = cyc + 1;
    e.name = name;
    e.note = n;
    e.gate = g;
    e.wave = w;
    e.mode = m;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  logic [3:0] arp_kc   [20] = '{4'h0, 4'hF, 4'h4, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0] arp_note [20] = '{4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4,
                                4'd4, 4'd7, 4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4};

  initial begin
    logic [3:0] kc;
    logic [3:0] en;
    n_rst      = 1'b0;
    keycode    = 4'hF;
    mode_edge  = 1'b0;
    sound_edge = 1'b0;
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b1;

    // LIVE
    chk(4'hF, 0, 0, "reset",        4'd0, 0, 2'd0, 2'd0);
    chk(4'h4, 0, 0, "live_press4",  4'd4, 1, 2'd0, 2'd0);
    chk(4'hF, 0, 0, "live_release", 4'd4, 0, 2'd0, 2'd0);

    // waveform and mode cycling
    for (int i = 1; i <= 5; i++) chk(4'hF, 0, 1, "wave_step", 4'd4, 0, 2'(i), 2'd0);
    chk(4'h5, 0, 0, "live_press5",  4'd5, 1, 2'd1, 2'd0);
    chk(4'h5, 1, 0, "mode_to_hold", 4'd5, 0, 2'd1, 2'd1);
    chk(4'hF, 1, 0, "mode_to_arp",  4'd5, 0, 2'd1, 2'd2);
    chk(4'hF, 1, 0, "mode_to_live", 4'd5, 0, 2'd1, 2'd0);

    // HOLD
    chk(4'hF, 1, 0, "enter_hold",      4'd5, 0, 2'd1, 2'd1);
    chk(4'h7, 0, 0, "hold_press7",     4'd7, 1, 2'd1, 2'd1);
    chk(4'hF, 0, 0, "hold_release7",   4'd7, 1, 2'd1, 2'd1);
    chk(4'h7, 0, 0, "hold_toggle_off", 4'd7, 0, 2'd1, 2'd1);
    chk(4'hF, 0, 0, "hold_release",    4'd7, 0, 2'd1, 2'd1);
    chk(4'h2, 0, 0, "hold_press2",     4'd2, 1, 2'd1, 2'd1);
    for (int i = 0; i < 10; i++) chk(4'h2, 0, 0, "hold_keep2", 4'd2, 1, 2'd1, 2'd1);
    chk(4'hF, 0, 0, "hold_release2",   4'd2, 1, 2'd1, 2'd1);

    // ARP playback 0,4,7 with ticks every 4 cycles
    chk(4'hF, 1, 0, "enter_arp", 4'd2, 0, 2'd1, 2'd2);
    for (int i = 0; i < 20; i++)
      chk(arp_kc[i], 0, 0, "arp_play", arp_note[i], (i >= 3), 2'd1, 2'd2);

    // ARP fill past capacity; ninth key must not appear in playback
    chk(4'hF, 1, 0, "arp_to_live", 4'd4, 0, 2'd1, 2'd0);
    chk(4'hF, 1, 0, "to_hold",     4'd4, 0, 2'd1, 2'd1);
    chk(4'hF, 1, 0, "to_arp",      4'd4, 0, 2'd1, 2'd2);
    for (int e = 1; e <= 36; e++) begin
      if (e <= 8)      kc = (e % 2 == 1) ? 4'h1 : 4'h2;
      else if (e == 9) kc = 4'h9;
      else             kc = 4'hF;
      if (e < 4) chk(kc, 0, 0, "arp_full", 4'd4, 0, 2'd1, 2'd2);
      else begin
        en = ((e / 4) % 2 == 1) ? 4'd1 : 4'd2;
        chk(kc, 0, 0, "arp_full", en, 1, 2'd1, 2'd2);
      end
    end
    chk(4'hF, 1, 0, "full_to_live", 4'd1, 0, 2'd1, 2'd0);
    chk(4'hF, 1, 0, "full_to_hold", 4'd1, 0, 2'd1, 2'd1);
    chk(4'hF, 1, 0, "full_to_arp",  4'd1, 0, 2'd1, 2'd2);
    for (int i = 0; i < 8; i++) chk(4'hF, 0, 0, "arp_cleared", 4'd1, 0, 2'd1, 2'd2);

    // mode_edge coincident with a new key
    chk(4'hF, 1, 0, "prio_to_live", 4'd1, 0, 2'd1, 2'd0);
    chk(4'hF, 1, 0, "prio_to_hold", 4'd1, 0, 2'd1, 2'd1);
    chk(4'h6, 1, 0, "prio_edgekey", 4'd1, 0, 2'd1, 2'd2);
    for (int i = 0; i < 8; i++) chk(4'hF, 0, 0, "prio_not_rec", 4'd1, 0, 2'd1, 2'd2);

    // asynchronous reset mid-arpeggio
    chk(4'h3, 0, 0, "rst_arp_load", 4'd1, 0, 2'd1, 2'd2);
    chk(4'hF, 0, 0, "rst_arp_wait", 4'd1, 0, 2'd1, 2'd2);
    chk(4'hF, 0, 0, "rst_arp_wait", 4'd1, 0, 2'd1, 2'd2);
    chk(4'hF, 0, 0, "rst_arp_play", 4'd3, 1, 2'd1, 2'd2);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if (note !== 4'd0 || gate !== 1'b0 || mode !== 2'd0 || wave_sel !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset: got note=%0d gate=%0d wave=%0d mode=%0d, want all 0",
               note, gate, wave_sel, mode);
    end
    #1 n_rst = 1'b1;
    chk(4'hF, 0, 0, "post_reset", 4'd0, 0, 2'd0, 2'd0);

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
